// File: rtl/clock_meter_pkg.sv
// Shared definitions for the clock_meter gate-window frequency counter:
// FSM state encoding and gate length derivation.
package clock_meter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_COUNT = 2'd1;
  localparam state_t ST_LATCH = 2'd2;

  function automatic int unsigned gate_cycles_of(input int unsigned freq, input int unsigned rate);
    return freq / rate;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous input into the clock domain and emits a one-cycle
// pulse for each rising edge of the synchronized level.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic delay_r;

  // two synchronizer stages plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      delay_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      delay_r <= sync2_r;
    end
  end

  assign rise = sync2_r & ~delay_r;

endmodule

// File: rtl/clock_meter.sv
// Gate-window frequency meter: counts rising edges of Sig_in over a fixed
// number of Clk_in cycles and publishes the count with a Done pulse.
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned frecuency = 32'd50000000,
  parameter int unsigned gate_rate = 32'd1000,
  parameter int unsigned CNT_WIDTH = 32'd16
) (
  input  logic                 Clk_in,
  input  logic                 reset,
  input  logic                 Sig_in,
  input  logic                 Start,
  input  logic                 Continuous,
  output logic                 Busy,
  output logic                 Done,
  output logic [CNT_WIDTH-1:0] Count,
  output logic                 Overflow
);

  localparam int unsigned GATE_CYCLES = gate_cycles_of(frecuency, gate_rate);
  localparam int unsigned GATE_W      = (GATE_CYCLES < 32'd2) ? 32'd1 : $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  generate
    if (GATE_CYCLES < 32'd2) begin : gen_gate_check
      $error("clock_meter: gate window must be at least 2 Clk_in cycles");
    end
  endgenerate

  state_t              state_r;
  logic [GATE_W-1:0]   gate_r;
  logic [CNT_WIDTH-1:0] edge_r;
  logic                ovf_r;
  logic [CNT_WIDTH-1:0] edge_nxt_s;
  logic                ovf_nxt_s;
  logic                rise_s;

  edge_sync u_sig_sync (
    .clk   (Clk_in),
    .rst_n (reset),
    .din   (Sig_in),
    .rise  (rise_s)
  );

  // saturating edge count; a rise at full scale only raises the overflow flag
  always_comb begin
    edge_nxt_s = edge_r;
    ovf_nxt_s  = ovf_r;
    if (rise_s) begin
      if (edge_r == CNT_MAX) begin
        ovf_nxt_s = 1'b1;
      end else begin
        edge_nxt_s = edge_r + CNT_WIDTH'(1'b1);
      end
    end else begin
      edge_nxt_s = edge_r;
      ovf_nxt_s  = ovf_r;
    end
  end

  // gate FSM; the final COUNT cycle's rise is included in the latched result
  always_ff @(posedge Clk_in or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      gate_r   <= '0;
      edge_r   <= '0;
      ovf_r    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            state_r <= ST_COUNT;
            Busy    <= 1'b1;
            gate_r  <= '0;
            edge_r  <= '0;
            ovf_r   <= 1'b0;
          end
        end
        ST_COUNT: begin
          edge_r <= edge_nxt_s;
          ovf_r  <= ovf_nxt_s;
          if (gate_r == GATE_LAST) begin
            state_r  <= ST_LATCH;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Count    <= edge_nxt_s;
            Overflow <= ovf_nxt_s;
          end else begin
            gate_r <= gate_r + GATE_W'(1'b1);
          end
        end
        ST_LATCH: begin
          Done   <= 1'b0;
          gate_r <= '0;
          edge_r <= '0;
          ovf_r  <= 1'b0;
          if (Continuous) begin
            state_r <= ST_COUNT;
            Busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_meter.sv
// Self-checking bench for clock_meter with a shortened gate (1000 cycles)
// and an 8-bit counter so that saturation is reachable.
module tb_clock_meter;

  localparam int FREQ = 50000000;
  localparam int RATE = 50000;
  localparam int GATE = FREQ / RATE;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk_in = 1'b0;
  logic          reset = 1'b0;
  logic          Sig_in = 1'b0;
  logic          Start = 1'b0;
  logic          Continuous = 1'b0;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Count;
  logic          Overflow;

  int tests = 0;
  int failed = 0;

  int sig_mode = 0;
  int sig_period = 2;
  int sig_high = 1;

  always #10 Clk_in = ~Clk_in;

  clock_meter #(
    .frecuency (FREQ),
    .gate_rate (RATE),
    .CNT_WIDTH (CW)
  ) dut (
    .Clk_in     (Clk_in),
    .reset      (reset),
    .Sig_in     (Sig_in),
    .Start      (Start),
    .Continuous (Continuous),
    .Busy       (Busy),
    .Done       (Done),
    .Count      (Count),
    .Overflow   (Overflow)
  );

  // Measured waveform: constant low/high or periodic with given high time.
  initial begin : sig_gen
    int phase;
    phase = 0;
    forever begin
      @(negedge Clk_in);
      if (sig_mode == 2) begin
        phase = (phase + 1) % sig_period;
        Sig_in = (phase < sig_high);
      end else begin
        Sig_in = (sig_mode == 1);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference model: a periodic signal puts GATE/period edges in a gate, +-1.
  task automatic model(output int lo, output int hi, output int ovf);
    int nominal;
    nominal = (sig_mode == 2) ? GATE / sig_period : 0;
    if (sig_mode != 2) begin
      lo = 0; hi = 0; ovf = 0;
    end else if (nominal - 1 > CMAX) begin
      lo = CMAX; hi = CMAX; ovf = 1;
    end else begin
      lo = (nominal > 0) ? nominal - 1 : 0;
      hi = (nominal + 1 > CMAX) ? CMAX : nominal + 1;
      ovf = 0;
    end
  endtask

  task automatic set_sig(input int mode, input int period, input int high);
    sig_mode = mode;
    sig_period = period;
    sig_high = high;
    repeat (10) @(negedge Clk_in);
  endtask

  task automatic wait_done(input int drop_at, output int cyc, output logic busy1);
    cyc = 0;
    busy1 = 1'bx;
    do begin
      @(negedge Clk_in);
      cyc++;
      if (cyc == 1) begin
        Start = 1'b0;
        busy1 = Busy;
      end
      if (cyc == drop_at) Continuous = 1'b0;
    end while (!Done && cyc < 2 * GATE + 20);
  endtask

  task automatic run_gate(input string tag);
    int cyc, lo, hi, ovf;
    logic busy1;
    model(lo, hi, ovf);
    @(negedge Clk_in);
    Start = 1'b1;
    wait_done(0, cyc, busy1);
    check({tag, "_busy_open"}, busy1, 1);
    check({tag, "_latency"}, cyc, GATE + 1);
    check({tag, "_busy_latch"}, Busy, 0);
    check_range({tag, "_count"}, Count, lo, hi);
    check({tag, "_overflow"}, Overflow, ovf);
    @(negedge Clk_in);
    check({tag, "_done_pulse"}, Done, 0);
    check({tag, "_busy_idle"}, Busy, 0);
  endtask

  initial begin
    int cyc, lo, hi, ovf, n_done, p;
    logic busy1;
    logic [CW-1:0] held;

    // reset state
    repeat (3) @(negedge Clk_in);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_count", Count, 0);
    check("rst_overflow", Overflow, 0);
    reset = 1'b1;

    // no measurement without Start
    n_done = 0;
    repeat (50) begin
      @(negedge Clk_in);
      if (Done) n_done++;
    end
    check("idle_no_done", n_done, 0);
    check("idle_busy", Busy, 0);

    set_sig(0, 2, 1);
    run_gate("const_low");
    set_sig(1, 2, 1);
    run_gate("const_high");
    set_sig(2, 50, 25);
    run_gate("p50");

    for (int k = 0; k < 5; k++) begin
      p = $urandom_range(60, 4);
      set_sig(2, p, $urandom_range(p - 1, 1));
      run_gate($sformatf("rand%0d_p%0d", k, p));
    end

    set_sig(2, 2, 1);
    run_gate("toggle_ovf");
    set_sig(2, 3, 1);
    run_gate("p3_ovf");

    // continuous mode, then drop Continuous mid-gate
    p = $urandom_range(60, 4);
    set_sig(2, p, $urandom_range(p - 1, 1));
    model(lo, hi, ovf);
    Continuous = 1'b1;
    @(negedge Clk_in);
    Start = 1'b1;
    wait_done(0, cyc, busy1);
    check("cont_first_latency", cyc, GATE + 1);
    for (int k = 0; k < 3; k++) begin
      wait_done((k == 2) ? GATE / 2 : 0, cyc, busy1);
      check($sformatf("cont%0d_busy_open", k), busy1, 1);
      check($sformatf("cont%0d_period", k), cyc, GATE + 1);
      check_range($sformatf("cont%0d_count", k), Count, lo, hi);
      check($sformatf("cont%0d_overflow", k), Overflow, ovf);
    end
    held = Count;
    n_done = 0;
    repeat (2 * GATE + 20) begin
      @(negedge Clk_in);
      if (Done) n_done++;
    end
    check("cont_stop_no_done", n_done, 0);
    check("cont_stop_busy", Busy, 0);
    check("cont_count_held", Count, held);

    // reset mid-gate aborts the measurement
    @(negedge Clk_in);
    Start = 1'b1;
    repeat (GATE / 2) begin
      @(negedge Clk_in);
      Start = 1'b0;
    end
    check("abort_busy_before", Busy, 1);
    reset = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_count", Count, 0);
    check("abort_overflow", Overflow, 0);
    @(negedge Clk_in);
    reset = 1'b1;
    n_done = 0;
    repeat (2 * GATE + 20) begin
      @(negedge Clk_in);
      if (Done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_idle_busy", Busy, 0);

    p = $urandom_range(60, 4);
    set_sig(2, p, $urandom_range(p - 1, 1));
    run_gate("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
